tri_host: RTL and testbench

- Host-side initiator for the 3-bit triangle rasterizer point interface (nt/xi/yi in, busy/po/xo/yo out).
- Accepts one triangle request on a valid/ready port and serialises its three vertices onto nt/xi/yi.
- Collects the returned point stream into an 8x8 occupancy bitmap with a point count.
- Reports completion with a done pulse and error flags. Sits between the test/control logic and the rasterizer.

---
 rtl/tri_pkg.sv | 33 +++
 rtl/tri_point_collector.sv | 63 ++++++
 rtl/tri_host.sv | 138 +++++++++++++
 tb/tb_tri_host.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tri_pkg.sv
// Shared definitions for the triangle rasterizer point interface.
// Used by the rasterizer and by tri_host / tri_point_collector.
//   COORD_W  : width of one coordinate (x or y)
//   GRID     : grid edge length (points per row/column)
//   state_t  : tri_host control states
//   vertex_t : packed {x,y} vertex, matching the req_vtx field layout
//   bm_index : bitmap bit position {y,x} of a point
package tri_pkg;

    localparam int COORD_W = 3;
    localparam int GRID    = 8;
    localparam int CELLS   = GRID * GRID;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND0   = 3'd1,
        SEND1   = 3'd2,
        SEND2   = 3'd3,
        COLLECT = 3'd4,
        DONE    = 3'd5
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } vertex_t;

    function automatic logic [2*COORD_W-1:0] bm_index(input logic [COORD_W-1:0] x,
                                                      input logic [COORD_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/tri_point_collector.sv
// Point collector: occupancy bitmap, saturating point count, duplicate
// detection and COLLECT-phase watchdog.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : wipe bitmap/count/dup/watchdog (new triangle accepted)
//   en           : host is in COLLECT; points and watchdog only advance here
//   po, xo, yo   : point stream from the rasterizer
//   bitmap       : bit {yo,xo} set for every reported point
//   pt_count     : number of points seen, saturating at 64
//   dup          : sticky, a point hit an already-set bit
//   timeout      : high during the TIMEOUT-th enabled cycle
module tri_point_collector
    import tri_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               en,
    input  logic               po,
    input  logic [COORD_W-1:0] xo,
    input  logic [COORD_W-1:0] yo,
    output logic [CELLS-1:0]   bitmap,
    output logic [6:0]         pt_count,
    output logic               dup,
    output logic               timeout
);

    localparam logic [7:0] WD_LAST  = 8'(TIMEOUT - 1);
    localparam logic [6:0] CNT_MAX  = 7'(CELLS);

    logic [7:0]             wd;
    logic [2*COORD_W-1:0]   idx;

    assign idx     = bm_index(xo, yo);
    // wd counts completed COLLECT cycles, so this cycle is number wd+1.
    assign timeout = en && (wd == WD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitmap   <= '0;
            pt_count <= '0;
            dup      <= 1'b0;
            wd       <= '0;
        end else if (clear) begin
            bitmap   <= '0;
            pt_count <= '0;
            dup      <= 1'b0;
            wd       <= '0;
        end else if (en) begin
            if (wd != 8'hFF)
                wd <= wd + 8'd1;
            if (po) begin
                bitmap[idx] <= 1'b1;
                if (bitmap[idx])
                    dup <= 1'b1;
                if (pt_count != CNT_MAX)
                    pt_count <= pt_count + 7'd1;
            end
        end
    end

endmodule

// File: rtl/tri_host.sv
// Host-side initiator for the 3-bit triangle rasterizer.
// Takes one triangle on a valid/ready port, serialises its three vertices
// onto nt/xi/yi, then collects the returned points into an 8x8 bitmap.
//   clk, reset_n        : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE with busy low)
//   req_vtx             : {x2,y2,x1,y1,x0,y0}
//   nt, xi, yi          : vertex stream to the rasterizer
//   busy, po, xo, yo    : rasterizer status and point stream
//   done                : one-cycle result-valid pulse
//   err                 : [0] protocol/timeout, [1] duplicate point
//   bitmap, pt_count    : collected points for the current triangle
module tri_host
    import tri_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [6*COORD_W-1:0] req_vtx,
    output logic                 nt,
    output logic [COORD_W-1:0]   xi,
    output logic [COORD_W-1:0]   yi,
    input  logic                 busy,
    input  logic                 po,
    input  logic [COORD_W-1:0]   xo,
    input  logic [COORD_W-1:0]   yo,
    output logic                 done,
    output logic [1:0]           err,
    output logic [CELLS-1:0]     bitmap,
    output logic [6:0]           pt_count
);

    state_t   state;
    vertex_t  v0_in;
    vertex_t  v1;
    vertex_t  v2;
    logic     proto_err;
    logic     dup;
    logic     timeout;
    logic     accept;

    assign req_ready = (state == IDLE) && !busy;
    assign accept    = req_valid && req_ready;
    assign v0_in     = vertex_t'(req_vtx[2*COORD_W-1:0]);
    assign err       = {dup, proto_err};

    tri_point_collector #(
        .TIMEOUT (TIMEOUT)
    ) u_collector (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (accept),
        .en       (state == COLLECT),
        .po       (po),
        .xo       (xo),
        .yo       (yo),
        .bitmap   (bitmap),
        .pt_count (pt_count),
        .dup      (dup),
        .timeout  (timeout)
    );

    // Outputs are set on the edge entering each state so they are valid for
    // the whole of that state; vertex 0 goes out straight from the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            nt        <= 1'b0;
            xi        <= '0;
            yi        <= '0;
            done      <= 1'b0;
            proto_err <= 1'b0;
            v1        <= '0;
            v2        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        v1        <= vertex_t'(req_vtx[4*COORD_W-1:2*COORD_W]);
                        v2        <= vertex_t'(req_vtx[6*COORD_W-1:4*COORD_W]);
                        proto_err <= 1'b0;
                        nt        <= 1'b1;
                        xi        <= v0_in.x;
                        yi        <= v0_in.y;
                        state     <= SEND0;
                    end
                end
                SEND0: begin
                    nt    <= 1'b0;
                    xi    <= v1.x;
                    yi    <= v1.y;
                    state <= SEND1;
                end
                SEND1: begin
                    xi    <= v2.x;
                    yi    <= v2.y;
                    state <= SEND2;
                end
                SEND2: begin
                    xi <= '0;
                    yi <= '0;
                    // The rasterizer must have taken the triangle by now.
                    if (!busy) begin
                        proto_err <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (!busy) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (timeout) begin
                        proto_err <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    nt    <= 1'b0;
                    xi    <= '0;
                    yi    <= '0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_host.sv
// Directed testbench for tri_host (TIMEOUT overridden to 16).
module tb_tri_host;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [17:0] req_vtx;
    logic        nt;
    logic [2:0]  xi;
    logic [2:0]  yi;
    logic        busy;
    logic        po;
    logic [2:0]  xo;
    logic [2:0]  yo;
    logic        done;
    logic [1:0]  err;
    logic [63:0] bitmap;
    logic [6:0]  pt_count;

    int checks   = 0;
    int failures = 0;

    tri_host #(
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_vtx   (req_vtx),
        .nt        (nt),
        .xi        (xi),
        .yi        (yi),
        .busy      (busy),
        .po        (po),
        .xo        (xo),
        .yo        (yo),
        .done      (done),
        .err       (err),
        .bitmap    (bitmap),
        .pt_count  (pt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns in SEND0.
    task automatic send_req(input logic [17:0] v);
        req_vtx   = v;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_vtx   = '0;
        busy      = 1'b0;
        po        = 1'b0;
        xo        = '0;
        yo        = '0;
        #1;
        chk("rst_nt", nt, 0);
        chk("rst_xiyi", {xi, yi}, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_bitmap", bitmap, 0);
        chk("rst_cnt", pt_count, 0);
        chk("rst_ready", req_ready, 1);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Handshake and point capture: {x2=4,y2=4,x1=4,y1=1,x0=1,y0=1}
        send_req({3'd4, 3'd4, 3'd4, 3'd1, 3'd1, 3'd1});
        chk("hs_nt0", nt, 1);
        chk("hs_v0", {xi, yi}, {3'd1, 3'd1});
        chk("hs_ready", req_ready, 0);
        tick();
        chk("hs_nt1", nt, 0);
        chk("hs_v1", {xi, yi}, {3'd4, 3'd1});
        busy = 1'b1;
        tick();
        chk("hs_nt2", nt, 0);
        chk("hs_v2", {xi, yi}, {3'd4, 3'd4});
        tick();
        chk("col_xiyi0", {xi, yi}, 0);
        po = 1'b1; xo = 3'd1; yo = 3'd1;
        tick();
        po = 1'b0;
        tick();
        tick();
        po = 1'b1; xo = 3'd2; yo = 3'd1;
        tick();
        po = 1'b0;
        tick();
        tick();
        po = 1'b1; xo = 3'd3; yo = 3'd2;
        tick();
        po = 1'b0;
        busy = 1'b0;
        chk("cap_nodone", done, 0);
        tick();
        chk("cap_done", done, 1);
        chk("cap_bitmap", bitmap, 64'h0000_0000_0008_0600);
        chk("cap_cnt", pt_count, 3);
        chk("cap_err", err, 0);
        tick();
        chk("cap_done_pulse", done, 0);
        chk("cap_ready", req_ready, 1);
        chk("cap_hold", pt_count, 3);

        // Duplicate point at (5,6) -> bit 53
        send_req({3'd2, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0});
        busy = 1'b1;
        tick();
        tick();
        tick();
        po = 1'b1; xo = 3'd5; yo = 3'd6;
        tick();
        tick();
        po = 1'b0;
        busy = 1'b0;
        tick();
        chk("dup_done", done, 1);
        chk("dup_bitmap", bitmap, 64'h0020_0000_0000_0000);
        chk("dup_cnt", pt_count, 2);
        chk("dup_err", err, 2'b10);
        tick();
        // po in IDLE is ignored
        po = 1'b1; xo = 3'd0; yo = 3'd0;
        tick();
        po = 1'b0;
        chk("idle_po_bitmap", bitmap, 64'h0020_0000_0000_0000);
        chk("idle_po_cnt", pt_count, 2);
        chk("idle_po_err", err, 2'b10);

        // Protocol error: busy never rises
        send_req({3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0});
        chk("pe_clear_err", err, 0);
        tick();
        tick();
        chk("pe_nodone", done, 0);
        tick();
        chk("pe_done", done, 1);
        chk("pe_err", err, 2'b01);
        chk("pe_cnt", pt_count, 0);
        chk("pe_bitmap", bitmap, 0);
        tick();

        // Timeout: busy stays high for the whole collection
        send_req({3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0});
        busy = 1'b1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("to_nodone", done, 0);
        chk("to_noerr", err, 0);
        tick();
        chk("to_done", done, 1);
        chk("to_err", err, 2'b01);
        tick();
        chk("to_busy_ready", req_ready, 0);
        busy = 1'b0;
        #1;
        chk("to_ready", req_ready, 1);
        tick();

        // Backpressure: request while busy is ignored
        busy      = 1'b1;
        req_vtx   = {3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        req_valid = 1'b1;
        #1;
        chk("bp_ready", req_ready, 0);
        tick();
        chk("bp_nt0", nt, 0);
        tick();
        chk("bp_nt1", nt, 0);
        req_valid = 1'b0;
        busy      = 1'b0;
        tick();

        // Reset during SEND1
        send_req({3'd6, 3'd5, 3'd3, 3'd2, 3'd1, 3'd1});
        tick();
        chk("mr_send1", {xi, yi}, {3'd3, 3'd2});
        reset_n = 1'b0;
        #1;
        chk("mr_nt", nt, 0);
        chk("mr_xiyi", {xi, yi}, 0);
        chk("mr_ready", req_ready, 1);
        chk("mr_err", err, 0);
        tick();
        reset_n = 1'b1;
        begin
            int seen_done;
            seen_done = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (done) seen_done++;
            end
            chk("mr_nodone", seen_done, 0);
        end
        chk("mr_nt_after", nt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
